seg_scan_ctrl: RTL and testbench
================================

# seg_scan_ctrl

Front-end stage for the two-digit seven-segment display path. It synchronises and debounces the two raw slide switches, and divides the board clock into the digit-scan signal that alternates the display between its right and left digits. It also produces a blanking window after every digit swap to suppress ghosting. Outputs feed the display driver's `switch0`, `switch1` and `clock` (scan) inputs directly.

## Interface
- `SCAN_DIV`, default 100000: clock cycles per digit phase; legal range ≥ 2.
- `BLANK_CYCLES`, default 2: cycles at the start of each phase with `blank` high; legal range 0 ≤ `BLANK_CYCLES` < `SCAN_DIV`.
- `DEBOUNCE_CYCLES`, default 500000: consecutive mismatching cycles required before a switch output changes; legal range ≥ 1.
- `clock` input 1: the design's single clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `switch0_raw` input 1: asynchronous slide-switch input selecting the write block.
- `switch1_raw` input 1: asynchronous slide-switch input selecting the read block.
- `switch0` output 1: synchronised, debounced `switch0_raw`.
- `switch1` output 1: synchronised, debounced `switch1_raw`.
- `sw_changed` output 1: one-cycle pulse when either debounced switch output changes.
- `scan` output 1: digit select.
  - 0 selects the right digit.
  - 1 selects the left digit.
- `scan_tick` output 1: one-cycle pulse in the cycle `scan` toggles.
- `blank` output 1: high while the current phase is inside its blanking window.

## Operation
- Synchroniser: a two-flop chain per raw input (`sN_meta` → `sN_sync`); both flops reset to 0.
- Debouncer, one per switch, with a counter of width $clog2(DEBOUNCE_CYCLES+1):
  - If `sN_sync` equals the output, the counter clears to 0.
  - If they differ and the counter equals `DEBOUNCE_CYCLES-1`, the output takes `sN_sync` and the counter clears.
  - If they differ otherwise, the counter increments.
  - Any single matching cycle during a mismatch run restarts the count from 0.
- `sw_changed` is registered. It is high in the cycle after either output's update edge, for exactly one cycle, even if both switches change on the same edge.
- Scan divider, with a counter `phase_cnt` of width $clog2(SCAN_DIV):
  - Counts 0..`SCAN_DIV-1`, then wraps to 0.
  - On the wrap edge, `scan` toggles and `scan_tick` is registered high for one cycle.
  - `scan_tick` is otherwise low.
- Blanking: `blank` is a combinational decode, high when `phase_cnt < BLANK_CYCLES`. With `BLANK_CYCLES` = 0, `blank` is constant 0.
- The scan divider and the debouncers are fully independent; switch activity never perturbs the scan phase.

## Timing
- Reset values, in the cycle after a reset edge:
  - `switch0`, `switch1`, `sw_changed`, `scan`, `scan_tick`: 0.
  - `phase_cnt`: 0.
  - All debounce counters: 0.
  - `blank`: 1 if `BLANK_CYCLES` > 0.
- Reset asserted mid-operation overrides all counting on that edge, including a pending wrap or debounce completion. There is no toggle and no pulse on a reset edge.
- Scan cadence:
  - First `scan` toggle occurs on the `SCAN_DIV`-th rising edge after reset deasserts.
  - Thereafter `scan` toggles every `SCAN_DIV` edges, giving a full scan period of 2·`SCAN_DIV`.
  - `scan_tick` coincides with the first cycle of each new phase, as does the start of the `blank` window.
- Switch latency: let raw input settle before rising edge N and remain stable. The output changes on edge N+1+`DEBOUNCE_CYCLES`.
- Simultaneous scan wrap and debounce completion on the same edge: both take effect; neither is delayed.

## Configuration
- `SEG_SCAN_DEBOUNCE_EN` defined: debouncers as described.
- `SEG_SCAN_DEBOUNCE_EN` undefined:
  - Debounce counters are removed.
  - Each output is `sN_sync` registered once, giving a fixed latency of output change on edge N+2, identical to `DEBOUNCE_CYCLES` = 1.
  - `DEBOUNCE_CYCLES` is ignored.
  - `sw_changed` still pulses on every output change.

## Test plan
Common parameters: `SCAN_DIV`=8, `BLANK_CYCLES`=2, `DEBOUNCE_CYCLES`=4, macro defined.
- Reset 3 cycles, then run 40 cycles:
  - `scan` toggles at edges 8, 16, 24, 32 after deassert.
  - `scan_tick` is high exactly in those 4 cycles.
  - `blank` is high for `phase_cnt` 0–1 of each phase.
- Raise `switch0_raw` before edge N and hold:
  - `switch0` goes 0→1 on edge N+5.
  - `sw_changed` pulses once.
  - `switch1` stays 0.
- Bounce `switch1_raw`: 1 for 3 cycles, 0 for 1 cycle, then 1 held → `switch1` rises only 5 edges after the final rise is sampled; no intermediate change.
- Toggle both raw switches in the same cycle → both outputs change on the same edge; `sw_changed` is a single one-cycle pulse.
- Assert `reset` for 1 cycle at `phase_cnt`=7 with a debounce count at 3 → no toggle and no switch change; all outputs return to their reset values; the next toggle occurs 8 edges later.
- Macro undefined, raw switch rises before edge N → output changes on edge N+2; a 1-cycle glitch propagates as a 1-cycle output pulse.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: switch synchroniser/debouncer and digit-scan divider for the
// two-digit seven-segment display path.
//
// Build option: define SEG_SCAN_DEBOUNCE_EN to enable the counting debouncers.
// Without it each switch output is its synchronised input registered once.
module seg_scan_ctrl #(
  parameter int unsigned SCAN_DIV        = 100000,
  parameter int unsigned BLANK_CYCLES    = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clock,
  input  logic reset,
  input  logic switch0_raw,
  input  logic switch1_raw,
  output logic switch0,
  output logic switch1,
  output logic sw_changed,
  output logic scan,
  output logic scan_tick,
  output logic blank
);

  localparam int unsigned PhaseW = $clog2(SCAN_DIV);
  localparam logic [PhaseW-1:0] PhaseLast = PhaseW'(SCAN_DIV - 1);

  // Reject illegal configurations at elaboration time.
  if (SCAN_DIV < 2) begin : g_bad_scan_div
    $error("seg_scan_ctrl: SCAN_DIV must be at least 2");
  end
  if (BLANK_CYCLES >= SCAN_DIV) begin : g_bad_blank
    $error("seg_scan_ctrl: BLANK_CYCLES must be below SCAN_DIV");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("seg_scan_ctrl: DEBOUNCE_CYCLES must be at least 1");
  end

  // Index 0 is switch0, index 1 is switch1.
  logic [1:0] w_raw;
  logic [1:0] r_meta;
  logic [1:0] r_sync;
  logic [1:0] r_sw;
  logic [1:0] w_sw_nxt;
  logic [1:0] w_sw_upd;
  logic       r_sw_changed;

  logic [PhaseW-1:0] r_phase_cnt;
  logic              w_wrap;
  logic              r_scan;
  logic              r_scan_tick;

  assign w_raw = {switch1_raw, switch0_raw};

  // Two-flop synchroniser per raw switch input.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_meta <= 2'b00;
      r_sync <= 2'b00;
    end else begin
      r_meta <= w_raw;
      r_sync <= r_meta;
    end
  end

`ifdef SEG_SCAN_DEBOUNCE_EN
  localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);

  logic [DbW-1:0] r_db_cnt [2];
  logic [DbW-1:0] w_db_cnt_nxt [2];

  // Debounce decision: a run of DEBOUNCE_CYCLES mismatches moves the output;
  // any matching cycle restarts the run.
  always_comb begin
    w_sw_nxt = r_sw;
    for (int i = 0; i < 2; i++) begin
      w_db_cnt_nxt[i] = r_db_cnt[i];
      if (r_sync[i] == r_sw[i]) begin
        w_db_cnt_nxt[i] = '0;
      end else if (r_db_cnt[i] == DbLast) begin
        w_sw_nxt[i]     = r_sync[i];
        w_db_cnt_nxt[i] = '0;
      end else begin
        w_db_cnt_nxt[i] = r_db_cnt[i] + DbW'(1);
      end
    end
  end

  // Debounce counter state.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_db_cnt[0] <= '0;
      r_db_cnt[1] <= '0;
    end else begin
      r_db_cnt[0] <= w_db_cnt_nxt[0];
      r_db_cnt[1] <= w_db_cnt_nxt[1];
    end
  end
`else
  // No filtering: the output follows the synchronised input one edge later.
  always_comb begin
    w_sw_nxt = r_sync;
  end
`endif

  assign w_sw_upd = w_sw_nxt ^ r_sw;

  // Switch outputs and the registered change pulse (one pulse even when both move).
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sw         <= 2'b00;
      r_sw_changed <= 1'b0;
    end else begin
      r_sw         <= w_sw_nxt;
      r_sw_changed <= |w_sw_upd;
    end
  end

  assign w_wrap = (r_phase_cnt == PhaseLast);

  // Scan divider: count a phase, toggle the digit select and pulse on the wrap edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_phase_cnt <= '0;
      r_scan      <= 1'b0;
      r_scan_tick <= 1'b0;
    end else begin
      r_phase_cnt <= w_wrap ? '0 : r_phase_cnt + PhaseW'(1);
      r_scan      <= r_scan ^ w_wrap;
      r_scan_tick <= w_wrap;
    end
  end

  // Blanking window at the start of each phase; absent when BLANK_CYCLES is 0.
  if (BLANK_CYCLES == 0) begin : g_no_blank
    assign blank = 1'b0;
  end else begin : g_blank
    assign blank = (32'(r_phase_cnt) < BLANK_CYCLES);
  end

  assign switch0    = r_sw[0];
  assign switch1    = r_sw[1];
  assign sw_changed = r_sw_changed;
  assign scan       = r_scan;
  assign scan_tick  = r_scan_tick;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: directed scenarios followed by random
// switch/reset activity, compared every edge against a history-based model.
module tb_seg_scan_ctrl;

  localparam int SD    = 8;
  localparam int BLANK = 2;
  localparam int DB    = 4;
`ifdef SEG_SCAN_DEBOUNCE_EN
  localparam int DEFF = DB;
`else
  localparam int DEFF = 1;
`endif
  localparam int MAXE = 4096;

  logic clock = 1'b0;
  logic reset;
  logic switch0_raw;
  logic switch1_raw;
  logic switch0;
  logic switch1;
  logic sw_changed;
  logic scan;
  logic scan_tick;
  logic blank;

  seg_scan_ctrl #(
    .SCAN_DIV       (SD),
    .BLANK_CYCLES   (BLANK),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .switch0_raw(switch0_raw),
    .switch1_raw(switch1_raw),
    .switch0    (switch0),
    .switch1    (switch1),
    .sw_changed (sw_changed),
    .scan       (scan),
    .scan_tick  (scan_tick),
    .blank      (blank)
  );

  always #5 clock = ~clock;

  // Model state: raw value present at each edge, last reset edge, and the
  // number of non-reset edges since then.
  logic rawh0 [MAXE];
  logic rawh1 [MAXE];
  int   t        = -1;
  int   rst_edge = 0;
  int   n_since  = 0;
  logic m_sw0, m_sw1, m_chg, m_scan, m_tick, m_blank;

  int n_vec  = 0;
  int n_miss = 0;

  // Value the debouncer sees at edge tt: raw from two edges earlier, or the
  // synchroniser's reset value just after a reset.
  function automatic logic dbin(input int w, input int tt);
    if (tt - rst_edge <= 2) return 1'b0;
    return (w == 0) ? rawh0[tt-2] : rawh1[tt-2];
  endfunction

  // Output moves at edge tt after DEFF consecutive edges of disagreement.
  function automatic logic db_change(input int w, input int tt, input logic cur);
    if (tt - rst_edge < DEFF) return 1'b0;
    for (int k = 0; k < DEFF; k++) begin
      if (dbin(w, tt - k) == cur) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic check(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s at edge %0d: observed=%b expected=%b", tag, t, obs, exp);
    end
  endtask

  // Apply inputs for one rising edge, advance the model, then compare.
  task automatic step(input logic rst, input logic r0, input logic r1);
    logic c0, c1;
    reset       = rst;
    switch0_raw = r0;
    switch1_raw = r1;
    @(posedge clock);
    t++;
    if (t >= MAXE) begin
      $display("FAIL edge_budget: edge %0d exceeds history of %0d", t, MAXE);
      $fatal(1, "history overflow");
    end
    rawh0[t] = r0;
    rawh1[t] = r1;
    if (rst) begin
      rst_edge = t;
      n_since  = 0;
      m_sw0    = 1'b0;
      m_sw1    = 1'b0;
      m_chg    = 1'b0;
    end else begin
      n_since++;
      c0    = db_change(0, t, m_sw0);
      c1    = db_change(1, t, m_sw1);
      m_sw0 = m_sw0 ^ c0;
      m_sw1 = m_sw1 ^ c1;
      m_chg = c0 | c1;
    end
    m_scan  = ((n_since / SD) % 2) == 1;
    m_tick  = (n_since > 0) && ((n_since % SD) == 0);
    m_blank = (n_since % SD) < BLANK;
    #1;
    check("switch0", switch0, m_sw0);
    check("switch1", switch1, m_sw1);
    check("sw_changed", sw_changed, m_chg);
    check("scan", scan, m_scan);
    check("scan_tick", scan_tick, m_tick);
    check("blank", blank, m_blank);
  endtask

  initial begin
    logic r0, r1, rs;
    reset       = 1'b1;
    switch0_raw = 1'b0;
    switch1_raw = 1'b0;

    // Reset for 3 edges, then free-run the scan divider for 40 edges.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b0, 1'b0, 1'b0);

    // Raise switch0 and hold.
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0);

    // Bounce switch1: 1 x3, 0 x1, then 1 held.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1);

    // Drop both switches together.
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0);

    // Reset on the wrap edge while a switch0 debounce is one edge from completing.
    step(1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 2; i++) step(1'b0, 1'b0, 1'b0);
    for (int i = 3; i <= 7; i++) step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b0);

    // Single-cycle glitch on switch1.
    step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0);

    // Random activity: occasional flips give both glitches and long holds.
    r0 = 1'b1;
    r1 = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 7) == 0) r0 = ~r0;
      if ($urandom_range(0, 7) == 0) r1 = ~r1;
      rs = ($urandom_range(0, 119) == 0);
      step(rs, r0, r1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
